uart_rx_ctrl: RTL and testbench

- Sequencing controller for the UART RX datapath; sits between the serial line and the existing deserializer and data sampler.
- Detects the start bit, runs the per-bit oversampling edge counter and the frame bit counter, and issues `deserializer_enable` with `bit_cnt` 1..8 for data bits, LSB first.
- Checks parity and stop, and raises `data_valid` when a clean byte is in `P_DATA`.

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_edge_bit_counter.sv | 56 +++++
 rtl/uart_rx_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX sequencing logic: FSM state encoding
// and the frame bit-index constants used by the controller and its counter.
package uart_rx_pkg;

    // IDLE must stay at zero so that reset and the idle state coincide.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    // Frame bit indices as seen on bit_cnt.
    localparam logic [3:0] BIT_START = 4'd0;
    localparam logic [3:0] BIT_PAR   = 4'd9;

    // The downstream deserializer is fixed at one byte.
    localparam int DATA_BITS = 8;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter. The edge counter runs
// 0..prescale-1 while enabled; each wrap advances the bit index. A clear
// returns both counters to the start-bit position.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [PRESCALE_W-1:0] edge_cnt_o,
    output logic [3:0]            bit_cnt_o,
    output logic                  wrap_o
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [3:0]            bit_cnt_q,  bit_cnt_d;

    // Last oversampling edge of the current bit period.
    assign wrap_o = (edge_cnt_q == (prescale_i - PRESCALE_W'(1)));

    // Next-state: clear has priority, otherwise count while enabled.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (clr_i) begin
            edge_cnt_d = '0;
            bit_cnt_d  = BIT_START;
        end else if (en_i) begin
            if (wrap_o) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 4'd1;
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
            end
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
    assign bit_cnt_o  = bit_cnt_q;

endmodule : uart_rx_edge_bit_counter

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencing controller. Detects the start bit, steps through the
// frame with the edge/bit counter, strobes the deserializer at each data-bit
// sample point, checks parity and stop, and flags a clean byte.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int DATA_BITS  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  sample_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  deserializer_enable,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    state_e state_q, state_d;

    logic par_acc_q,    par_acc_d;
    logic par_err_q,    par_err_d;
    logic stp_err_q,    stp_err_d;
    logic data_valid_q, data_valid_d;

    logic                  deser_en;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  wrap;
    logic                  at_sample;
    logic [PRESCALE_W-1:0] sample_pt;

    // The sampler votes on edges prescale/2-1..prescale/2+1 and registers
    // the result, so its output is final two edges past mid-bit.
    assign sample_pt = (prescale >> 1) + PRESCALE_W'(2);
    assign at_sample = (edge_cnt == sample_pt);

    // Counters run in every active state and are parked at zero whenever
    // the FSM is in, or about to enter, IDLE. This also drops the last
    // half of the stop bit so a back-to-back start edge is not missed.
    assign cnt_en  = (state_q != IDLE);
    assign cnt_clr = (state_q == IDLE) || (state_d == IDLE);

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W)
    ) u_cnt (
        .clk_i      (CLK),
        .rst_n_i    (RST),
        .en_i       (cnt_en),
        .clr_i      (cnt_clr),
        .prescale_i (prescale),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt),
        .wrap_o     (wrap)
    );

    // Next-state, parity/stop checks and strobes for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        par_acc_d    = par_acc_q;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;
        data_valid_d = 1'b0;
        deser_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d   = START;
                    par_acc_d = 1'b0;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            START: begin
                // A start bit that reads high at its centre was a glitch.
                if (at_sample && sampled_bit) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_sample) begin
                    deser_en  = 1'b1;
                    par_acc_d = par_acc_q ^ sampled_bit;
                end
                if (wrap && (bit_cnt == 4'(DATA_BITS))) begin
                    state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_sample) begin
                    par_err_d = sampled_bit ^ par_acc_q ^ PAR_TYP;
                end
                if (wrap) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_sample) begin
                    stp_err_d    = ~sampled_bit;
                    data_valid_d = sampled_bit & ~par_err_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= IDLE;
            par_acc_q    <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_acc_q    <= par_acc_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign sample_en           = (state_q != IDLE);
    assign deserializer_enable = deser_en;
    assign data_valid          = data_valid_q;
    assign par_err             = par_err_q;
    assign stp_err             = stp_err_q;

endmodule : uart_rx_ctrl

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl. The bench plays both the serial line and
// the data sampler (sampled_bit follows the driven bit level), models the
// downstream deserializer, and checks timing against hand-derived cycles.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] prescale = 6'd8;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          sampled_bit = 1'b1;
    logic          sample_en;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          deserializer_enable;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    uart_rx_ctrl #(
        .PRESCALE_W (PW),
        .DATA_BITS  (8)
    ) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .RX_IN               (RX_IN),
        .prescale            (prescale),
        .PAR_EN              (PAR_EN),
        .PAR_TYP             (PAR_TYP),
        .sampled_bit         (sampled_bit),
        .sample_en           (sample_en),
        .edge_cnt            (edge_cnt),
        .bit_cnt             (bit_cnt),
        .deserializer_enable (deserializer_enable),
        .data_valid          (data_valid),
        .par_err             (par_err),
        .stp_err             (stp_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int         de_cyc[$];
    int         de_bit[$];
    int         dv_cyc[$];
    logic [7:0] p_data = 8'h00;

    // Snapshots taken while a frame is being driven.
    logic        pre_se, pre_par, pre_stp;
    logic [12:0] st_out;
    logic [3:0]  rst_bc;
    logic [31:0] rst_out;

    // Cycle counter, pulse logger and deserializer model.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (deserializer_enable) begin
            de_cyc.push_back(cyc);
            de_bit.push_back(int'(bit_cnt));
            if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8)
                p_data[3'(bit_cnt - 4'd1)] <= sampled_bit;
        end
        if (data_valid) dv_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({sample_en, edge_cnt, bit_cnt, deserializer_enable,
                    data_valid, par_err, stp_err});
    endfunction

    task automatic clear_logs();
        de_cyc.delete();
        de_bit.delete();
        dv_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            RX_IN       = 1'b1;
            sampled_bit = 1'b1;
        end
    endtask

    // Drive one frame. t0 is the first cycle the DUT should spend in START.
    // rst_at >= 0 pulses RST low at cycle t0+rst_at and abandons the frame.
    task automatic send(input logic [7:0] b, input logic pbit, input logic sbit,
                        input int stop_len, input int rst_at, output int t0);
        logic lv[11];
        int   nb;
        int   p;
        bit   first;
        p     = int'(prescale);
        lv[0] = 1'b0;
        for (int i = 0; i < 8; i++) lv[i+1] = b[i];
        if (PAR_EN) begin
            lv[9] = pbit; lv[10] = sbit; nb = 11;
        end else begin
            lv[9] = sbit; lv[10] = 1'b1; nb = 10;
        end
        t0    = 0;
        first = 1'b1;
        for (int k = 0; k < nb; k++) begin
            int len;
            len = (k == nb - 1) ? stop_len : p;
            for (int c = 0; c < len; c++) begin
                @(negedge CLK);
                if (first) begin
                    t0      = cyc + 1;
                    pre_se  = sample_en;
                    pre_par = par_err;
                    pre_stp = stp_err;
                    first   = 1'b0;
                end
                if (cyc == t0) st_out = {sample_en, edge_cnt, bit_cnt, par_err, stp_err};
                if (rst_at >= 0 && cyc == t0 + rst_at) begin
                    rst_bc      = bit_cnt;
                    RST         = 1'b0;
                    RX_IN       = lv[k];
                    sampled_bit = lv[k];
                    @(negedge CLK);
                    RST         = 1'b1;
                    RX_IN       = 1'b1;
                    sampled_bit = 1'b1;
                    rst_out     = outs();
                    return;
                end
                RX_IN       = lv[k];
                sampled_bit = lv[k];
            end
        end
    endtask

    initial begin
        int t, t2;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("reset_outs", outs(), 32'h0);
        RST = 1'b1;
        idle(3);

        // 1: prescale 8, no parity, 0xA5
        prescale = 6'd8; PAR_EN = 1'b0;
        clear_logs();
        send(8'hA5, 1'b0, 1'b1, 8, -1, t);
        idle(12);
        chk("t1_start", 32'(st_out), 32'h1000);
        chk("t1_de_count", de_cyc.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_de_cycle", de_cyc[i] - t, 14 + 8 * i);
            chk("t1_de_bitcnt", de_bit[i], i + 1);
        end
        chk("t1_dv_count", dv_cyc.size(), 1);
        chk("t1_dv_cycle", dv_cyc[0] - t, 79);
        chk("t1_pdata", p_data, 8'hA5);
        chk("t1_errs", {par_err, stp_err}, 2'b00);
        chk("t1_idle", sample_en, 1'b0);

        // 2: prescale 16, even parity, 0x97 with parity bit 1
        prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        clear_logs();
        send(8'h97, 1'b1, 1'b1, 16, -1, t);
        idle(4);
        chk("t2_de_count", de_cyc.size(), 8);
        chk("t2_dv_count", dv_cyc.size(), 1);
        chk("t2_dv_cycle", dv_cyc[0] - t, 171);
        chk("t2_pdata", p_data, 8'h97);
        chk("t2_errs", {par_err, stp_err}, 2'b00);

        // 3: same frame, parity bit flipped, then a clean frame
        clear_logs();
        send(8'h97, 1'b0, 1'b1, 16, -1, t);
        idle(6);
        chk("t3_par_err", par_err, 1'b1);
        chk("t3_stp_err", stp_err, 1'b0);
        chk("t3_no_dv", dv_cyc.size(), 0);
        clear_logs();
        send(8'h97, 1'b1, 1'b1, 16, -1, t);
        idle(4);
        chk("t3_par_sticky", pre_par, 1'b1);
        chk("t3_par_clr_start", 32'(st_out), 32'h1000);
        chk("t3_clean_dv", dv_cyc.size(), 1);
        chk("t3_clean_par", par_err, 1'b0);

        // 4: stop bit low on 0x3C, next frame starts on the first IDLE cycle
        prescale = 6'd8; PAR_EN = 1'b0;
        clear_logs();
        send(8'h3C, 1'b0, 1'b0, 8, -1, t);
        send(8'h81, 1'b0, 1'b1, 8, -1, t2);
        idle(12);
        chk("t4_stp_err", pre_stp, 1'b1);
        chk("t4_back_idle", pre_se, 1'b0);
        chk("t4_next_start", 32'(st_out), 32'h1000);
        chk("t4_dv_count", dv_cyc.size(), 1);
        chk("t4_dv_cycle", dv_cyc[0] - t2, 79);
        chk("t4_pdata", p_data, 8'h81);
        chk("t4_stp_clr", stp_err, 1'b0);

        // 5: 3-cycle glitch on RX_IN
        clear_logs();
        @(negedge CLK);
        t = cyc + 1;
        RX_IN = 1'b0; sampled_bit = 1'b0;
        repeat (2) @(negedge CLK);
        @(negedge CLK);
        RX_IN = 1'b1; sampled_bit = 1'b1;
        while (cyc < t + 6) @(negedge CLK);
        chk("t5_active_at_sp", {sample_en, edge_cnt}, {1'b1, 6'd6});
        @(negedge CLK);
        chk("t5_abandoned", {sample_en, edge_cnt, bit_cnt}, 11'd0);
        idle(10);
        chk("t5_no_de", de_cyc.size(), 0);
        chk("t5_no_dv", dv_cyc.size(), 0);

        // 6: reset mid-DATA, then a full 0xFF frame with even parity
        clear_logs();
        send(8'h5A, 1'b0, 1'b1, 8, 35, t);
        chk("t6_bitcnt_at_rst", rst_bc, 4'd4);
        chk("t6_rst_outs", rst_out, 32'h0);
        idle(100);
        chk("t6_no_dv", dv_cyc.size(), 0);
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        clear_logs();
        send(8'hFF, 1'b0, 1'b1, 8, -1, t);
        idle(4);
        chk("t6_dv_count", dv_cyc.size(), 1);
        chk("t6_dv_cycle", dv_cyc[0] - t, 87);
        chk("t6_pdata", p_data, 8'hFF);
        chk("t6_errs", {par_err, stp_err}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_rx_ctrl
